// File: rtl/maint_cmd_sched.sv
// Maintenance command scheduler: arbitrates REF/ZQCS/PRD requests, stalls the host, precharges, issues one command.
// Latency: grant one cycle after a sampled request; ack lands the command's busy time + 1 cycles after acceptance.
// Backpressure: PREA/ISSUE hold valid and type until maint_cmd_ready; host_stall stays high for the whole sequence.
// Build option MAINT_SCHED_PRD_EN: periodic reads are arbitrated; otherwise they are auto-acked with no command.
module maint_cmd_sched #(
  parameter int TCQ      = 100,
  parameter int TRP_CK   = 6,
  parameter int TRFC_CK  = 64,
  parameter int TZQCS_CK = 32,
  parameter int TPRD_CK  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dfi_init_complete,
  input  logic       autoref_req,
  output logic       autoref_ack,
  input  logic       zq_req,
  output logic       zq_ack,
  input  logic       periodic_rd_req,
  output logic       periodic_rd_ack,
  output logic       host_stall,
  input  logic       host_idle,
  input  logic       banks_open,
  output logic       maint_cmd_valid,
  output logic [1:0] maint_cmd_type,
  input  logic       maint_cmd_ready,
  output logic       maint_busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAIN     = 3'd1,
    S_PREA      = 3'd2,
    S_WAIT_RP   = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_ACK       = 3'd6
  } state_e;

  localparam logic [1:0] CMD_PREA = 2'd0;
  localparam logic [1:0] CMD_REF  = 2'd1;
  localparam logic [1:0] CMD_ZQCS = 2'd2;
  localparam logic [1:0] CMD_PRD  = 2'd3;

  // Timing parameters are carried in an 8-bit down-counter, so only the low byte matters.
  localparam logic [7:0] TRP_T   = 8'(TRP_CK);
  localparam logic [7:0] TRFC_T  = 8'(TRFC_CK);
  localparam logic [7:0] TZQCS_T = 8'(TZQCS_CK);
  localparam logic [7:0] TPRD_T  = 8'(TPRD_CK);

  // TCQ is kept on the interface for behavioural-model compatibility; registers here carry no delay.
  if (TCQ < 0) begin : g_tcq_negative
  end

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] timer_q, timer_d;
  logic       prd_arb;
  logic       any_req;
  logic [1:0] win_sel;
  logic [7:0] done_time;
  logic       prd_seq_ack;

`ifdef MAINT_SCHED_PRD_EN
  assign prd_arb = periodic_rd_req;
`else
  assign prd_arb = 1'b0;
`endif

  assign any_req = autoref_req | zq_req | prd_arb;

  // Fixed priority pick: REF over ZQCS over PRD.
  always_comb begin
    win_sel = CMD_PRD;
    if (autoref_req) begin
      win_sel = CMD_REF;
    end else if (zq_req) begin
      win_sel = CMD_ZQCS;
    end
  end

  // Busy time of the command latched for this sequence.
  always_comb begin
    done_time = TPRD_T;
    case (sel_q)
      CMD_REF:  done_time = TRFC_T;
      CMD_ZQCS: done_time = TZQCS_T;
      default:  done_time = TPRD_T;
    endcase
  end

  // State, selected command and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= CMD_PREA;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
    end
  end

  // Sequence control: next state, timer loads and Moore outputs.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    timer_d         = timer_q;
    maint_cmd_valid = 1'b0;
    maint_cmd_type  = CMD_PREA;
    autoref_ack     = 1'b0;
    zq_ack          = 1'b0;
    prd_seq_ack     = 1'b0;
    host_stall      = (state_q != S_IDLE);
    maint_busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (dfi_init_complete && any_req) begin
          state_d = S_DRAIN;
          sel_d   = win_sel;
        end
      end
      S_DRAIN: begin
        // Periodic reads work on whatever banks are open; only REF/ZQCS need them closed.
        if (host_idle) begin
          state_d = (banks_open && (sel_q != CMD_PRD)) ? S_PREA : S_ISSUE;
        end
      end
      S_PREA: begin
        maint_cmd_valid = 1'b1;
        maint_cmd_type  = CMD_PREA;
        if (maint_cmd_ready) begin
          timer_d = TRP_T;
          state_d = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        timer_d = timer_q - 8'd1;
        if (timer_q == 8'd1) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        maint_cmd_valid = 1'b1;
        maint_cmd_type  = sel_q;
        if (maint_cmd_ready) begin
          timer_d = done_time;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        timer_d = timer_q - 8'd1;
        if (timer_q == 8'd1) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        autoref_ack = (sel_q == CMD_REF);
        zq_ack      = (sel_q == CMD_ZQCS);
        prd_seq_ack = (sel_q == CMD_PRD);
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Losing PHY init abandons the sequence without an ack; the request is retried later.
    if ((state_q != S_IDLE) && !dfi_init_complete) begin
      state_d = S_IDLE;
      timer_d = 8'd0;
    end
  end

`ifdef MAINT_SCHED_PRD_EN
  assign periodic_rd_ack = prd_seq_ack;
`else
  logic prd_req_q;
  logic prd_ack_q;

  // Auto-ack: one-cycle pulse on each rising edge of the periodic-read request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prd_req_q <= 1'b0;
      prd_ack_q <= 1'b0;
    end else begin
      prd_req_q <= periodic_rd_req;
      prd_ack_q <= periodic_rd_req & ~prd_req_q;
    end
  end

  // PRD never wins arbitration in this build, so the sequence ack term stays low.
  assign periodic_rd_ack = prd_ack_q | prd_seq_ack;
`endif

endmodule

// File: tb/tb_maint_cmd_sched.sv
// Bench for maint_cmd_sched: randomized request bursts scored against a per-sequence timeline model.
// Latency: the model derives every cycle's expected outputs from drain length, stall lengths and busy times.
// Backpressure: ready is dropped for chosen cycle counts inside each command presentation window.
module tb_maint_cmd_sched;

  localparam int TRP  = 6;
  localparam int TRFC = 64;
  localparam int TZQ  = 32;
  localparam int TPRD = 8;
`ifdef MAINT_SCHED_PRD_EN
  localparam bit PRD_EN = 1'b1;
`else
  localparam bit PRD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dfi_init_complete;
  logic       autoref_req;
  logic       autoref_ack;
  logic       zq_req;
  logic       zq_ack;
  logic       periodic_rd_req;
  logic       periodic_rd_ack;
  logic       host_stall;
  logic       host_idle;
  logic       banks_open;
  logic       maint_cmd_valid;
  logic [1:0] maint_cmd_type;
  logic       maint_cmd_ready;
  logic       maint_busy;

  int n_checks = 0;
  int n_errors = 0;
  bit pend_ref = 1'b0;
  bit pend_zq  = 1'b0;
  bit pend_prd = 1'b0;

  maint_cmd_sched dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dfi_init_complete (dfi_init_complete),
    .autoref_req       (autoref_req),
    .autoref_ack       (autoref_ack),
    .zq_req            (zq_req),
    .zq_ack            (zq_ack),
    .periodic_rd_req   (periodic_rd_req),
    .periodic_rd_ack   (periodic_rd_ack),
    .host_stall        (host_stall),
    .host_idle         (host_idle),
    .banks_open        (banks_open),
    .maint_cmd_valid   (maint_cmd_valid),
    .maint_cmd_type    (maint_cmd_type),
    .maint_cmd_ready   (maint_cmd_ready),
    .maint_busy        (maint_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (busy,stall,valid,type[2],ref_ack,zq_ack,prd_ack) t=%0t",
               tag, obs, exp_v, $time);
    end
  endtask

  // Output snapshot: {busy, stall, valid, type[1:0], autoref_ack, zq_ack, periodic_rd_ack}.
  function automatic logic [7:0] out_vec();
    return {maint_busy, host_stall, maint_cmd_valid, maint_cmd_type, autoref_ack, zq_ack, periodic_rd_ack};
  endfunction

  // One maintenance sequence, cycle 0 being the IDLE cycle in which the pending requests are sampled.
  // h: cycles host_idle stays low after the grant; r1/r2: ready-low cycles for PREA/ISSUE; b: banks_open.
  task automatic run_seq(input int h, input int r1, input int r2, input bit b);
    int win, t, c, pa, is_k, ia, ak;
    bit pre, prea_win, issue_win;
    logic [7:0] exp_v;
    win  = pend_ref ? 1 : (pend_zq ? 2 : 3);
    t    = (win == 1) ? TRFC : ((win == 2) ? TZQ : TPRD);
    pre  = b && (win != 3);
    c    = h + 1;                          // last DRAIN cycle
    pa   = pre ? c + 1 + r1 : c;           // PREA acceptance cycle
    is_k = pre ? pa + TRP + 1 : c + 1;     // first ISSUE cycle
    ia   = is_k + r2;                      // ISSUE acceptance cycle
    ak   = ia + t + 1;                     // ack cycle
    for (int k = 0; k <= ak; k++) begin
      @(negedge clk);
      prea_win          = pre && (k >= c + 1) && (k <= pa);
      issue_win         = (k >= is_k) && (k <= ia);
      dfi_init_complete = 1'b1;
      autoref_req       = pend_ref;
      zq_req            = pend_zq;
      periodic_rd_req   = pend_prd;
      host_idle         = (k > h);
      banks_open        = b;
      maint_cmd_ready   = !((prea_win && (k < pa)) || (issue_win && (k < ia)));
      exp_v = 8'h00;
      if (k >= 1) exp_v[7:6] = 2'b11;
      if (prea_win || issue_win) exp_v[5] = 1'b1;
      if (issue_win) exp_v[4:3] = win[1:0];
      if (k == ak) exp_v[3 - win] = 1'b1;
      check_eq($sformatf("seq_w%0d_k%0d", win, k), out_vec(), exp_v);
    end
    if (win == 1) pend_ref = 1'b0;
    else if (win == 2) pend_zq = 1'b0;
    else pend_prd = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    autoref_req     = 1'b0;
    zq_req          = 1'b0;
    periodic_rd_req = 1'b0;
    maint_cmd_ready = 1'b1;
    check_eq(tag, out_vec(), 8'h00);
  endtask

  initial begin
    rst_n             = 1'b0;
    dfi_init_complete = 1'b1;
    autoref_req       = 1'b1;
    zq_req            = 1'b1;
    periodic_rd_req   = 1'b0;
    host_idle         = 1'b1;
    banks_open        = 1'b1;
    maint_cmd_ready   = 1'b1;
    #1;
    check_eq("reset_initial", out_vec(), 8'h00);
    repeat (2) @(negedge clk);
    check_eq("reset_held", out_vec(), 8'h00);
    autoref_req = 1'b0;
    zq_req      = 1'b0;
    rst_n       = 1'b1;

    // Plain refresh, then refresh behind a precharge.
    pend_ref = 1'b1; run_seq(0, 0, 0, 1'b0);
    pend_ref = 1'b1; run_seq(0, 0, 0, 1'b1);

    // All requests together: served in priority order, back to back.
    pend_ref = 1'b1; pend_zq = 1'b1; pend_prd = PRD_EN;
    while (pend_ref || pend_zq || pend_prd) run_seq(0, 0, 0, 1'b1);

    // Long drain and ready backpressure on both commands.
    pend_zq = 1'b1; run_seq(10, 5, 5, 1'b1);

    // Randomized bursts.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) idle_cycle("gap_idle");
      pend_ref = 1'($urandom_range(0, 1));
      pend_zq  = 1'($urandom_range(0, 1));
      pend_prd = PRD_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!(pend_ref || pend_zq || pend_prd)) pend_zq = 1'b1;
      while (pend_ref || pend_zq || pend_prd)
        run_seq(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Init loss during WAIT_DONE: back to IDLE, no ack, no regrant while init is low.
    @(negedge clk);
    autoref_req = 1'b1; zq_req = 1'b0; periodic_rd_req = 1'b0;
    host_idle = 1'b1; banks_open = 1'b0; maint_cmd_ready = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("initloss_waiting", out_vec(), 8'hC0);
    dfi_init_complete = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("initloss_idle%0d", k), out_vec(), 8'h00);
    end
    pend_ref = 1'b1; run_seq(0, 0, 0, 1'b0);

    // Asynchronous reset while a ZQCS command is presented.
    @(negedge clk);
    autoref_req = 1'b0; zq_req = 1'b1; periodic_rd_req = 1'b0;
    host_idle = 1'b1; banks_open = 1'b0; maint_cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_pre_valid", out_vec(), 8'hF0);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", out_vec(), 8'h00);
    zq_req = 1'b0;
    @(negedge clk);
    check_eq("async_reset_hold", out_vec(), 8'h00);
    rst_n = 1'b1; maint_cmd_ready = 1'b1;
    pend_zq = 1'b1; run_seq(0, 0, 0, 1'b0);

`ifndef MAINT_SCHED_PRD_EN
    // Periodic read auto-ack: single pulse one cycle after the rise, no stall, no command.
    @(negedge clk);
    zq_req = 1'b0; periodic_rd_req = 1'b1;
    check_eq("prd_echo_pre", out_vec(), 8'h00);
    @(negedge clk);
    check_eq("prd_echo_ack", out_vec(), 8'h01);
    @(negedge clk);
    check_eq("prd_echo_once", out_vec(), 8'h00);
    periodic_rd_req = 1'b0;
    @(negedge clk);
    check_eq("prd_echo_done", out_vec(), 8'h00);
`endif

    idle_cycle("final_idle");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
